// File: rtl/atsc_fpll_ctrl_pkg.sv
// fpll_ctrl_pkg: settings addresses, defaults, controller states and status field positions
package fpll_ctrl_pkg;
  localparam logic [7:0] SR_CTRL = 8'd130;
  localparam logic [7:0] SR_SPP = 8'd131;
  localparam logic [15:0] SPP_DEFAULT = 16'd512;
  localparam int MAX_INFLIGHT_DEF = 64;
  localparam int ST_STATE = 30;
  localparam int ST_ERR = 29;
  localparam int ST_INFL = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/atsc_fpll_ctrl_if.sv
// atsc_fpll_ctrl_if: 32-bit AXI-stream bundle; master drives tdata/tvalid/tlast, slave drives tready
interface atsc_fpll_ctrl_if;
  logic [31:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/atsc_fpll_ctrl_skid.sv
// fpll_skid_buf: 2-entry registered AXI-stream skid buffer, 32-bit data
// ports: clk/rst, in_* upstream stream, out_* registered downstream stream, count = entries held
module fpll_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  count
);
  logic [31:0] d1;
  logic live, push, pop;
  // live holds ready low while in reset and for the first cycle after release
  assign in_ready = live && count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      live <= 1'b0;
      count <= 2'd0;
      out_data <= '0;
      d1 <= '0;
    end else begin
      live <= 1'b1;
      count <= count + 2'(push) - 2'(pop);
      out_data <= pop ? (count == 2'd2 ? d1 : in_data) : (count == 2'd0 ? in_data : out_data);
      d1 <= ((count == 2'd1 && !pop) || (count == 2'd2 && pop)) ? in_data : d1;
    end
endmodule

// File: rtl/atsc_fpll_ctrl.sv
// atsc_fpll_ctrl: gates samples into the FPLL core, bounds in-flight samples, regenerates tlast, handles flush
// ports: ce_clk/ce_rst, settings bus (set_stb/set_addr/set_data), s_in (from wrapper), core_in/core_out
// (to/from HLS core), m_out (to wrapper, registered), status {state, err, 5'd0, inflight, pkt_cnt}
module atsc_fpll_ctrl
  import fpll_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                   ce_clk,
  input  logic                   ce_rst,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  atsc_fpll_ctrl_if.slave        s_in,
  atsc_fpll_ctrl_if.master       core_in,
  atsc_fpll_ctrl_if.slave        core_out,
  atsc_fpll_ctrl_if.master       m_out,
  output logic [31:0]            status
);
  state_t state, nxt;
  logic enable, flush_req, err;
  logic [15:0] spp, beat_cnt, pkt_cnt;
  logic [7:0] inflight;
  logic [1:0] count;
  logic gate, ctrl_wr, spp_wr, in_hs, out_hs, m_hs, core_empty, done;
  logic unused_bits;
  assign unused_bits = ^{set_data[31:16], core_out.tlast};
  assign ctrl_wr = set_stb && set_addr == SR_CTRL;
  assign spp_wr = set_stb && set_addr == SR_SPP;
  assign gate = state == RUN && inflight < 8'(MAX_INFLIGHT);
  assign core_in.tdata = s_in.tdata;
  assign core_in.tlast = s_in.tlast;
  assign core_in.tvalid = s_in.tvalid && gate;
  assign s_in.tready = core_in.tready && gate;
  assign in_hs = core_in.tvalid && core_in.tready;
  assign out_hs = core_out.tvalid && core_out.tready;
  assign m_hs = m_out.tvalid && m_out.tready;
  assign core_empty = state == DRAIN && inflight == 8'd0;
  // >= rather than == so that shrinking spp below the current position closes the packet on the next beat
  assign m_out.tlast = m_out.tvalid && (beat_cnt >= spp - 16'd1 || (core_empty && count == 2'd1));
  assign done = core_empty && count == 2'd0 && beat_cnt == 16'd0;
  fpll_skid_buf u_skid (
    .clk(ce_clk),
    .rst(ce_rst),
    .in_data(core_out.tdata),
    .in_valid(core_out.tvalid),
    .in_ready(core_out.tready),
    .out_data(m_out.tdata),
    .out_valid(m_out.tvalid),
    .out_ready(m_out.tready),
    .count(count)
  );
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (enable ? RUN : IDLE) :
          state == RUN ? ((flush_req || !enable) ? DRAIN : RUN) :
          state == DRAIN ? (done ? IDLE : DRAIN) : IDLE;
  end
  always_ff @(posedge ce_clk or posedge ce_rst)
    if (ce_rst) begin
      state <= IDLE;
      enable <= 1'b0;
      flush_req <= 1'b0;
      err <= 1'b0;
      spp <= SPP_DEFAULT;
      beat_cnt <= '0;
      pkt_cnt <= '0;
      inflight <= '0;
    end else begin
      state <= nxt;
      enable <= ctrl_wr ? set_data[0] : enable;
      flush_req <= (ctrl_wr && set_data[1]) || (flush_req && !done);
      spp <= spp_wr ? (set_data[15:0] == 16'd0 ? 16'd1 : set_data[15:0]) : spp;
      err <= err || (out_hs && inflight == 8'd0);
      inflight <= inflight + 8'(in_hs) - 8'(out_hs && inflight != 8'd0);
      // an already-closed packet leaves beat_cnt stale when the core empties in DRAIN; zero it there
      beat_cnt <= m_hs ? (m_out.tlast ? 16'd0 : beat_cnt + 16'd1) :
                  (core_empty && count == 2'd0) ? 16'd0 : beat_cnt;
      pkt_cnt <= pkt_cnt + 16'(m_hs && m_out.tlast);
    end
  always_comb begin
    status = '0;
    status[ST_STATE +: 2] = state;
    status[ST_ERR] = err;
    status[ST_INFL +: 8] = inflight;
    status[15:0] = pkt_cnt;
  end
endmodule

// File: tb/tb_atsc_fpll_ctrl.sv
// tb_atsc_fpll_ctrl: directed bench with a packet-level scoreboard model and a 3-cycle core model
module tb_atsc_fpll_ctrl;
  import fpll_ctrl_pkg::*;
  logic ce_clk = 1'b0;
  logic ce_rst = 1'b1;
  logic set_stb = 1'b0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] status;
  atsc_fpll_ctrl_if s_in();
  atsc_fpll_ctrl_if core_in();
  atsc_fpll_ctrl_if core_out();
  atsc_fpll_ctrl_if m_out();
  atsc_fpll_ctrl #(.MAX_INFLIGHT(8)) dut (
    .ce_clk(ce_clk),
    .ce_rst(ce_rst),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .s_in(s_in),
    .core_in(core_in),
    .core_out(core_out),
    .m_out(m_out),
    .status(status)
  );
  always #5 ce_clk = ~ce_clk;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  int m_beat = 0, m_pkt = 0, m_spp = 512, tl_n = 0, acc_n = 0;
  bit draining = 1'b0;
  logic [31:0] last_mask = '0;
  logic [31:0] seq = 32'h1000;
  logic [31:0] pipe_d[$];
  int pipe_t[$];
  int cyc = 0;
  bit core_stall = 1'b0, inject = 1'b0, rnd = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want_v);
    total++;
    if (act !== want_v) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, want_v);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ce_clk);
      #1;
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    tick(1);
    set_stb = 1'b0;
    if (a == SR_SPP) m_spp = d[15:0] == 16'd0 ? 1 : int'(d[15:0]);
  endtask
  task automatic send(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      s_in.tvalid = 1'b1;
      s_in.tdata = seq;
      s_in.tlast = seq[0];
      @(negedge ce_clk);
      if (s_in.tready) begin
        got++;
        seq++;
      end
      @(posedge ce_clk);
      #1;
    end
    s_in.tvalid = 1'b0;
  endtask
  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    chk("drain_empty", exp_q.size(), 0);
  endtask
  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget && status[31:30] != s; i++) tick(1);
    chk("state_wait", status[31:30], s);
  endtask
  task automatic reset_model();
    exp_q.delete();
    m_beat = 0;
    m_pkt = 0;
    m_spp = 512;
    draining = 1'b0;
  endtask
  // scoreboard: accepted samples must leave in order; tlast closes every spp beats or ends a drain
  always @(negedge ce_clk) begin : mon
    bit want;
    if (!ce_rst) begin
      if (m_out.tvalid && m_out.tready) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          want = (m_beat + 1 >= m_spp) || (draining && exp_q.size() == 1);
          chk("out_data", m_out.tdata, exp_q[0]);
          chk("out_tlast", m_out.tlast, want);
          void'(exp_q.pop_front());
          last_mask = {last_mask[30:0], want};
          m_beat = want ? 0 : m_beat + 1;
          m_pkt += int'(want);
          tl_n += int'(want);
        end
      end
      if (draining && exp_q.size() == 0) m_beat = 0;
      if (s_in.tvalid) chk("passthru", {core_in.tlast, core_in.tdata}, {s_in.tlast, s_in.tdata});
      if (s_in.tvalid && s_in.tready) begin
        exp_q.push_back(s_in.tdata);
        acc_n++;
      end
    end
  end
  // core model: fixed 3-cycle latency FIFO honouring out_TREADY
  initial begin : core
    bit acc, emit;
    logic [31:0] d;
    core_out.tvalid = 1'b0;
    core_out.tdata = '0;
    core_out.tlast = 1'b0;
    forever begin
      @(negedge ce_clk);
      acc = core_in.tvalid && core_in.tready;
      d = core_in.tdata;
      emit = core_out.tvalid && core_out.tready;
      @(posedge ce_clk);
      #2;
      cyc++;
      if (ce_rst) begin
        pipe_d.delete();
        pipe_t.delete();
      end else begin
        if (emit && pipe_d.size() != 0) begin
          void'(pipe_d.pop_front());
          void'(pipe_t.pop_front());
        end
        if (acc) begin
          pipe_d.push_back(d);
          pipe_t.push_back(cyc);
        end
      end
      core_out.tvalid = inject || (!core_stall && pipe_d.size() != 0 && cyc - pipe_t[0] >= 3);
      core_out.tdata = inject ? 32'hdead : (pipe_d.size() != 0 ? pipe_d[0] : '0);
    end
  end
  initial forever begin
    @(posedge ce_clk);
    #1;
    if (rnd) m_out.tready = 1'($urandom_range(0, 1));
  end
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int got, tl0;
    s_in.tvalid = 1'b0;
    s_in.tdata = '0;
    s_in.tlast = 1'b0;
    core_in.tready = 1'b1;
    m_out.tready = 1'b0;
    tick(3);
    s_in.tvalid = 1'b1;
    #1;
    chk("rst_s_ready", s_in.tready, 0);
    chk("rst_core_valid", core_in.tvalid, 0);
    chk("rst_core_ready", core_out.tready, 0);
    chk("rst_m_valid", m_out.tvalid, 0);
    chk("rst_m_last", m_out.tlast, 0);
    chk("rst_status", status, 0);
    tick(1);
    s_in.tvalid = 1'b0;
    ce_rst = 1'b0;
    tick(2);
    chk("ready_after_rst", core_out.tready, 1);
    wr(SR_SPP, 32'd4);
    wr(SR_CTRL, 32'd1);
    m_out.tready = 1'b1;
    send(12, 200, got);
    chk("t1_acc", got, 12);
    wait_empty(100);
    chk("t1_mask", last_mask[11:0], 12'h111);
    chk("t1_pkt", status[15:0], 3);
    chk("t1_pkt_model", m_pkt, 3);
    chk("t1_state", status[31:30], RUN);
    core_stall = 1'b1;
    send(20, 20, got);
    chk("t2_acc", got, 8);
    chk("t2_ready", s_in.tready, 0);
    chk("t2_infl", status[23:16], 8);
    send(5, 5, got);
    chk("t2_hold", got, 0);
    core_stall = 1'b0;
    wait_empty(200);
    chk("t2_pkt", status[15:0], 5);
    wr(SR_SPP, 32'd10);
    m_out.tready = 1'b0;
    send(6, 100, got);
    chk("t3_acc", got, 6);
    tick(6);
    wr(SR_CTRL, 32'd3);
    draining = 1'b1;
    tick(3);
    chk("t3_drain", status[31:30], DRAIN);
    chk("t3_gate", s_in.tready, 0);
    m_out.tready = 1'b1;
    wait_empty(100);
    wait_state(RUN, 20);
    draining = 1'b0;
    chk("t3_mask", last_mask[5:0], 6'b000001);
    chk("t3_pkt", status[15:0], 6);
    wr(SR_SPP, 32'd100);
    tl0 = tl_n;
    rnd = 1'b1;
    send(1000, 20000, got);
    chk("t4_acc", got, 1000);
    wait_empty(500);
    rnd = 1'b0;
    m_out.tready = 1'b1;
    chk("t4_tlasts", tl_n - tl0, 10);
    chk("t4_pkt", status[15:0], 16);
    chk("t4_pkt_model", m_pkt, 16);
    core_stall = 1'b1;
    send(5, 50, got);
    chk("t5_acc", got, 5);
    tick(4);
    chk("t5_infl", status[23:16], 5);
    s_in.tvalid = 1'b1;
    #2;
    ce_rst = 1'b1;
    reset_model();
    #1;
    chk("t5_s_ready", s_in.tready, 0);
    chk("t5_core_valid", core_in.tvalid, 0);
    chk("t5_core_ready", core_out.tready, 0);
    chk("t5_m_valid", m_out.tvalid, 0);
    chk("t5_m_last", m_out.tlast, 0);
    chk("t5_status", status, 0);
    tick(2);
    s_in.tvalid = 1'b0;
    ce_rst = 1'b0;
    core_stall = 1'b0;
    tick(2);
    chk("t5_status_rel", status, 0);
    wr(SR_CTRL, 32'd1);
    tl0 = tl_n;
    send(101, 400, got);
    chk("t5_acc2", got, 101);
    wait_empty(100);
    chk("t5_no_tlast", tl_n - tl0, 0);
    chk("t5_pkt", status[15:0], 0);
    wr(SR_SPP, 32'd8);
    send(6, 100, got);
    wait_empty(100);
    chk("t5_shrink_mask", last_mask[5:0], 6'b100000);
    chk("t5_pkt2", status[15:0], 1);
    wr(SR_SPP, 32'd3);
    send(4, 100, got);
    chk("t6_acc", got, 4);
    wait_empty(100);
    chk("t6_mask", last_mask[3:0], 4'b1001);
    chk("t6_pkt", status[15:0], 3);
    chk("no_err", status[ST_ERR], 0);
    m_out.tready = 1'b0;
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(2);
    chk("err_flag", status[ST_ERR], 1);
    chk("err_infl", status[23:16], 0);
    ce_rst = 1'b1;
    reset_model();
    tick(2);
    ce_rst = 1'b0;
    tick(1);
    chk("err_clear", status, 0);
    chk("err_m_valid", m_out.tvalid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
